wb_occf_sink: RTL
=================

WB_OCCF_SINK -- requirements
Module: wb_occf_sink

Interface
REQ-001 SHALL have parameter g_ADDR_WIDTH, default 4, fabric address width.
REQ-002 SHALL have parameter g_DATA_WIDTH, default 128, fabric data width; sel/bytesel width = g_DATA_WIDTH/8.
REQ-003 SHALL have parameter g_FIFO_DEPTH, default 8, output FIFO entries (power of 2, >= 4).
REQ-004 SHALL have parameter g_WITH_FIFO_INFERRED, default 1, 1 = inferred RAM FIFO, 0 = vendor primitive.
REQ-005 SHALL have port clk_i, in, 1, clock.
REQ-006 SHALL have port rst_n_i, in, 1, reset: asynchronous, active-high.
REQ-007 SHALL have ports snk_dat_i, in, g_DATA_WIDTH; snk_adr_i, in, g_ADDR_WIDTH; snk_sel_i, in, g_DATA_WIDTH/8; snk_cyc_i, in, 1; snk_stb_i, in, 1; snk_we_i, in, 1: pipelined Wishbone stream sink.
REQ-008 SHALL have ports snk_stall_o, out, 1; snk_ack_o, out, 1; snk_err_o, out, 1; snk_rty_o, out, 1: Wishbone responses.
REQ-009 SHALL have ports addr_o, out, g_ADDR_WIDTH; data_o, out, g_DATA_WIDTH; bytesel_o, out, g_DATA_WIDTH/8: plain beat payload.
REQ-010 SHALL have ports dvalid_o, sof_o, eof_o, out, 1 each: beat valid, first beat, last beat.
REQ-011 SHALL have port dreq_i, in, 1: downstream ready.

Function
REQ-012 SHALL accept a beat on a rising edge where snk_cyc_i & snk_stb_i & snk_we_i & !snk_stall_o.
REQ-013 SHALL ignore snk_stb_i while snk_cyc_i = 0, and beats with snk_we_i = 0 (ack still returned).
REQ-014 SHALL assert snk_ack_o for exactly one cycle, the cycle after each acceptance edge.
REQ-015 SHALL drive snk_rty_o = 0 permanently.
REQ-016 SHALL implement FSM IDLE / WAIT_FIRST / HOLD: IDLE->WAIT_FIRST on cyc=1; WAIT_FIRST->HOLD on accepted beat; WAIT_FIRST->IDLE on cyc=0 (empty cycle, nothing emitted); HOLD stays on accepted beat; HOLD->IDLE on cyc=0.
REQ-017 SHALL keep the most recent accepted beat in a one-entry hold register; a held beat SHALL be pushed to the FIFO with eof=0 when a further beat is accepted, or with eof=1 on the first cycle cyc=0 in HOLD.
REQ-018 SHALL tag the first beat accepted in WAIT_FIRST with sof=1, all others sof=0; a single-beat packet SHALL carry sof=1 and eof=1.
REQ-019 SHALL store {adr, dat, sel, sof, eof} per FIFO entry; FIFO SHALL be first-word-fall-through.
REQ-020 SHALL drive dvalid_o = !fifo_empty & dreq_i; FIFO pops on dvalid_o; addr_o/data_o/bytesel_o/sof_o/eof_o = FIFO head, zero when empty.
REQ-021 SHALL assert snk_stall_o when FIFO occupancy >= g_FIFO_DEPTH-2, reserving room for the hold register and one in-flight beat.
REQ-022 SHALL, if a push occurs with FIFO full (protocol violation), drop the beat and assert snk_err_o for one cycle instead of snk_ack_o.
REQ-023 SHALL handle simultaneous FIFO push and pop in the same cycle without occupancy change or data loss, including at full and empty.
REQ-024 SHALL present a beat on dvalid_o no earlier than 2 cycles after its push edge-equivalent: single-beat packet accepted at edge N, cyc=0 at edge N+1, dvalid_o possible from cycle after N+1.
REQ-025 SHALL accept back-to-back packets separated by a single cyc=0 cycle; the flush of the previous held beat occurs in that cycle.
REQ-026 SHALL use occupancy counter width clog2(g_FIFO_DEPTH)+1; pointers wrap modulo g_FIFO_DEPTH.

Reset
REQ-027 SHALL, while rst_n_i = 1, force FSM to IDLE, clear hold register, FIFO and counters, and drive all outputs to 0 except snk_stall_o = 1.
REQ-028 SHALL discard any partial packet on reset mid-operation; no eof is emitted for it.
REQ-029 SHALL release snk_stall_o to 0 on the first clk_i edge after rst_n_i deasserts.

Structure
REQ-030 SHALL take the fabric address codes, beat record type and width constants from shared package occf_pkg.
REQ-031 SHALL instantiate one sub-module occf_sync_fifo (FWFT, inferred or primitive per g_WITH_FIFO_INFERRED); all FSM/hold logic stays in wb_occf_sink.

Verification
REQ-032 Single beat dat=0x0123..EF adr=0 sel=0xFFFF, dreq=1 -> one dvalid_o with sof=1 eof=1, identical payload, one ack.
REQ-033 4-beat packet dat=1,2,3,4, dreq=1 -> dvalid_o beats 1..4, sof only on 1, eof only on 4, 4 acks.
REQ-034 dreq=0, 10-beat packet, depth 8 -> stall asserted when occupancy reaches 6; after dreq=1 all 10 beats delivered in order, no err.
REQ-035 cyc high 5 cycles with stb=0 -> no FIFO push, no dvalid_o, no ack.
REQ-036 two 2-beat packets with one-cycle cyc gap -> 4 beats out, sof/eof pattern 10,01,10,01.
REQ-037 reset asserted after beat 2 of 4 -> all outputs 0, stall=1; post-reset new single-beat packet delivered with sof=eof=1, no residue.

Source files
------------

// File: rtl/occf_pkg.sv
// Shared definitions for the OCCF stream sink: fabric address codes, default
// widths, sink FSM states, the beat record and a small sizing helper.
package occf_pkg;

    // Default fabric widths
    localparam int c_ADDR_WIDTH = 4;
    localparam int c_DATA_WIDTH = 128;
    localparam int c_SEL_WIDTH  = c_DATA_WIDTH / 8;

    // Fabric address codes carried on snk_adr_i
    localparam logic [c_ADDR_WIDTH-1:0] c_ADR_DATA   = 4'h0;
    localparam logic [c_ADDR_WIDTH-1:0] c_ADR_OOB    = 4'h1;
    localparam logic [c_ADDR_WIDTH-1:0] c_ADR_STATUS = 4'h2;
    localparam logic [c_ADDR_WIDTH-1:0] c_ADR_USER   = 4'h3;

    // Sink packet-framing states
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_HOLD       = 2'd2
    } sink_state_t;

    // One beat as stored in the output FIFO (default widths)
    typedef struct packed {
        logic [c_ADDR_WIDTH-1:0] adr;
        logic [c_DATA_WIDTH-1:0] dat;
        logic [c_SEL_WIDTH-1:0]  sel;
        logic                    sof;
        logic                    eof;
    } occf_beat_t;

    // Occupancy counter width: one extra bit so "full" is representable
    function automatic int f_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/occf_sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is visible on
// dout_o whenever the FIFO is not empty. Push while full is ignored unless a
// pop happens in the same cycle, so simultaneous push/pop never loses data.
module occf_sync_fifo
    import occf_pkg::*;
#(
    parameter int g_DEPTH         = 8,
    parameter int g_WIDTH         = 8,
    parameter int g_WITH_INFERRED = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                push_i,
    input  logic [g_WIDTH-1:0]                  din_i,
    input  logic                                pop_i,
    output logic [g_WIDTH-1:0]                  dout_o,
    output logic                                empty_o,
    output logic                                full_o,
    output logic [f_cnt_width(g_DEPTH)-1:0]     count_o
);

    localparam int c_PW = $clog2(g_DEPTH);
    localparam int c_CW = f_cnt_width(g_DEPTH);

    logic [c_PW-1:0] wr_ptr_reg;
    logic [c_PW-1:0] rd_ptr_reg;
    logic [c_CW-1:0] count_reg;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count_reg == '0);
    assign full_o  = (count_reg == c_CW'(g_DEPTH));
    assign count_o = count_reg;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
            else if (!do_push && do_pop) count_reg <= count_reg - 1'b1;
        end
    end

    generate
        if (g_WITH_INFERRED != 0) begin : g_inferred
            logic [g_WIDTH-1:0] mem [g_DEPTH];

            // Storage array written on push; head read combinationally for FWFT
            always_ff @(posedge clk_i) begin
                if (do_push) mem[wr_ptr_reg] <= din_i;
            end

            assign dout_o = mem[rd_ptr_reg];
        end else begin : g_primitive
            logic [g_WIDTH-1:0] slot_reg [g_DEPTH];

            // Register-file storage standing in for the vendor FIFO macro
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < g_DEPTH; i++) slot_reg[i] <= '0;
                end else if (do_push) begin
                    slot_reg[wr_ptr_reg] <= din_i;
                end
            end

            assign dout_o = slot_reg[rd_ptr_reg];
        end
    endgenerate

endmodule

// File: rtl/wb_occf_sink.sv
// Pipelined Wishbone stream sink. Beats are framed into packets by cyc; the
// newest beat waits in a one-entry hold register so that its eof flag can be
// decided (next beat arrives -> eof=0, cyc drops -> eof=1) before it enters
// the output FIFO.
module wb_occf_sink
    import occf_pkg::*;
#(
    parameter int g_ADDR_WIDTH         = c_ADDR_WIDTH,
    parameter int g_DATA_WIDTH         = c_DATA_WIDTH,
    parameter int g_FIFO_DEPTH         = 8,
    parameter int g_WITH_FIFO_INFERRED = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [g_DATA_WIDTH-1:0]   snk_dat_i,
    input  logic [g_ADDR_WIDTH-1:0]   snk_adr_i,
    input  logic [g_DATA_WIDTH/8-1:0] snk_sel_i,
    input  logic                      snk_cyc_i,
    input  logic                      snk_stb_i,
    input  logic                      snk_we_i,
    output logic                      snk_stall_o,
    output logic                      snk_ack_o,
    output logic                      snk_err_o,
    output logic                      snk_rty_o,
    output logic [g_ADDR_WIDTH-1:0]   addr_o,
    output logic [g_DATA_WIDTH-1:0]   data_o,
    output logic [g_DATA_WIDTH/8-1:0] bytesel_o,
    output logic                      dvalid_o,
    output logic                      sof_o,
    output logic                      eof_o,
    input  logic                      dreq_i
);

    localparam int c_SEL_W     = g_DATA_WIDTH / 8;
    localparam int c_REC_W     = g_ADDR_WIDTH + g_DATA_WIDTH + c_SEL_W + 2;
    localparam int c_CNT_W     = f_cnt_width(g_FIFO_DEPTH);
    localparam int c_SEL_LSB   = 2;
    localparam int c_DAT_LSB   = c_SEL_LSB + c_SEL_W;
    localparam int c_ADR_LSB   = c_DAT_LSB + g_DATA_WIDTH;
    // Two slots kept free: one for the hold register flush, one in-flight beat
    localparam logic [c_CNT_W-1:0] c_STALL_LVL = c_CNT_W'(g_FIFO_DEPTH - 2);

    sink_state_t               state_reg;
    logic [g_ADDR_WIDTH-1:0]   hold_adr_reg;
    logic [g_DATA_WIDTH-1:0]   hold_dat_reg;
    logic [c_SEL_W-1:0]        hold_sel_reg;
    logic                      hold_sof_reg;
    logic                      stall_reg;
    logic                      ack_reg;
    logic                      err_reg;

    logic                      accept;
    logic                      beat_req;
    logic                      push;
    logic                      push_eof;
    logic                      pop;
    logic                      overflow;
    logic                      push_ok;
    logic [c_CNT_W-1:0]        cnt_next;
    logic [c_REC_W-1:0]        fifo_din;
    logic [c_REC_W-1:0]        fifo_dout;
    logic [c_REC_W-1:0]        head;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [c_CNT_W-1:0]        fifo_count;

    // Any strobe while not stalled is answered; only writes carry payload
    assign beat_req = snk_cyc_i && snk_stb_i && !stall_reg;
    assign accept   = beat_req && snk_we_i;

    // Held beat leaves when displaced by a new beat or when the cycle ends
    assign push     = (state_reg == ST_HOLD) && (accept || !snk_cyc_i);
    assign push_eof = !snk_cyc_i;
    assign fifo_din = {hold_adr_reg, hold_dat_reg, hold_sel_reg, hold_sof_reg, push_eof};

    assign pop      = dvalid_o;
    assign overflow = push && fifo_full && !pop;
    assign push_ok  = push && !overflow;

    // Occupancy after the coming edge, used to register the stall flag
    always_comb begin
        cnt_next = fifo_count;
        if (push_ok && !pop)      cnt_next = fifo_count + 1'b1;
        else if (!push_ok && pop) cnt_next = fifo_count - 1'b1;
    end

    occf_sync_fifo #(
        .g_DEPTH         (g_FIFO_DEPTH),
        .g_WIDTH         (c_REC_W),
        .g_WITH_INFERRED (g_WITH_FIFO_INFERRED)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_n_i),
        .push_i  (push),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // Packet framing FSM plus registered Wishbone responses
    always_ff @(posedge clk_i or posedge rst_n_i) begin
        if (rst_n_i) begin
            state_reg <= ST_IDLE;
            stall_reg <= 1'b1;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            stall_reg <= (cnt_next >= c_STALL_LVL);
            ack_reg   <= beat_req && !overflow;
            err_reg   <= overflow;
            case (state_reg)
                ST_IDLE: begin
                    // A beat arriving together with the rising cyc opens the packet
                    if (accept)         state_reg <= ST_HOLD;
                    else if (snk_cyc_i) state_reg <= ST_WAIT_FIRST;
                end
                ST_WAIT_FIRST: begin
                    if (!snk_cyc_i)     state_reg <= ST_IDLE;
                    else if (accept)    state_reg <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!snk_cyc_i)     state_reg <= ST_IDLE;
                end
                default:                state_reg <= ST_IDLE;
            endcase
        end
    end

    // Hold register captures each accepted beat; first beat of a packet gets sof
    always_ff @(posedge clk_i or posedge rst_n_i) begin
        if (rst_n_i) begin
            hold_adr_reg <= '0;
            hold_dat_reg <= '0;
            hold_sel_reg <= '0;
            hold_sof_reg <= 1'b0;
        end else if (accept) begin
            hold_adr_reg <= snk_adr_i;
            hold_dat_reg <= snk_dat_i;
            hold_sel_reg <= snk_sel_i;
            hold_sof_reg <= (state_reg != ST_HOLD);
        end
    end

    assign head        = fifo_empty ? '0 : fifo_dout;
    assign dvalid_o    = !fifo_empty && dreq_i;
    assign addr_o      = head[c_ADR_LSB +: g_ADDR_WIDTH];
    assign data_o      = head[c_DAT_LSB +: g_DATA_WIDTH];
    assign bytesel_o   = head[c_SEL_LSB +: c_SEL_W];
    assign sof_o       = head[1];
    assign eof_o       = head[0];

    assign snk_stall_o = stall_reg;
    assign snk_ack_o   = ack_reg;
    assign snk_err_o   = err_reg;
    assign snk_rty_o   = 1'b0;

endmodule
